fetch_sequencer: RTL and testbench

Front end of the multi-cycle RV32 core. Owns the PC and the FETCH/DECODE/EXEC/MEM/WRITE phase counter. Issues instruction-memory reads and drives `state` and `instr_raw` into the decode stage. Applies the branch/jump outcome from the execute path at WRITE to select the next PC.

---
 rtl/fetch_sequencer.sv | 112 +++++++++++
 tb/tb_fetch_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Front end of the multi-cycle RV32 core. It owns the program counter and the
// FETCH -> DECODE -> EXEC -> MEM -> WRITE phase sequence. It issues
// instruction-memory reads, latches the fetched word for the decode stage,
// and applies the branch/jump outcome in WRITE to choose the next PC.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   imem_req        instruction read request (high in FETCH, low during rst)
//   imem_addr       instruction byte address, always equal to pc
//   imem_ack        read data valid this cycle (only honoured in FETCH)
//   imem_rdata      instruction word, sampled only on an accepted ack
//   stall           holds the sequence in MEM while high
//   branch_taken    redirect request, sampled in WRITE only
//   branch_target   redirect address, sampled in WRITE only
//   state           current phase: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WRITE
//   instr_raw       latched instruction for decode
//   pc              address of the instruction in flight
//   pc_plus4        pc + 4, combinational, modulo 2^32
//   retired         number of completed WRITE phases (wraps)
//
// Handshake: imem_req acts as valid and imem_ack as the response strobe. A
// read is accepted on the first clock edge where imem_req=1 and imem_ack=1;
// until then imem_addr is held stable. The request may be withdrawn without
// an ack only by reset, and the memory side must tolerate that.
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [2:0]  state,
    output logic [31:0] instr_raw,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WRITE  = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retired;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_target_aligned;

    // Wraps naturally at 2^32: 0xFFFFFFFC + 4 = 0.
    assign w_pc_plus4       = r_pc + 32'd4;
    // Clearing the two low bits covers jalr bit 0 and misaligned targets.
    assign w_target_aligned = branch_target & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (rst) begin
            // An ack arriving alongside reset is dropped here as well.
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_instr   <= NOP_INSTR;
            r_retired <= 32'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    // Wait indefinitely; rdata is only captured on ack.
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: r_state <= S_EXEC;
                S_EXEC:   r_state <= S_MEM;
                S_MEM: begin
                    if (!stall) begin
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_state   <= S_FETCH;
                    r_retired <= r_retired + 32'd1;
                    r_pc      <= branch_taken ? w_target_aligned : w_pc_plus4;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Request is gated by rst so it drops in the very cycle reset is raised.
    assign imem_req  = (r_state == S_FETCH) && !rst;
    assign imem_addr = r_pc;
    assign state     = r_state;
    assign instr_raw = r_instr;
    assign pc        = r_pc;
    assign pc_plus4  = w_pc_plus4;
    assign retired   = r_retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Drives directed and random instruction sequences through fetch_sequencer.
// A reference model (PC, retire count) predicts each instruction's pc,
// latched word, retire count and cycle latency; these are queued when the
// instruction is issued and popped by an independent monitor when the DUT
// shows the instruction in WRITE. Unused inputs carry random values in
// every phase where they must be ignored.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic [2:0]  state;
    logic [31:0] instr_raw;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] retired;

    fetch_sequencer #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .state         (state),
        .instr_raw     (instr_raw),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .retired       (retired)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] retired;
        logic [31:0] lat;
    } rec_t;

    rec_t exp_q[$];

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] pc_m  = RESET_PC;
    logic [31:0] ret_m = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic junk();
        branch_taken  = 1'($urandom_range(0, 1));
        branch_target = $urandom;
        stall         = 1'($urandom_range(0, 1));
        imem_ack      = 1'($urandom_range(0, 1));
        imem_rdata    = $urandom;
    endtask

    // Reset held for two edges; model and scoreboard are flushed with it.
    task automatic do_reset(input bit ack_during);
        junk();
        rst = 1'b1;
        imem_ack   = ack_during;
        imem_rdata = 32'hDEAD_BEEF;
        exp_q.delete();
        pc_m  = RESET_PC;
        ret_m = 32'd0;
        tick();
        imem_ack = 1'b0;
        tick();
        rst = 1'b0;
        imem_ack = 1'b0;
        branch_taken = 1'b0;
    endtask

    // Called with the DUT in its first FETCH cycle; returns in the next one.
    task automatic run_instr(input int ack_dly, input logic [31:0] rd, input int stall_cyc,
                             input logic br, input logic [31:0] tgt, input bit br_exec);
        rec_t r;
        r.pc      = pc_m;
        r.instr   = rd;
        r.retired = ret_m;
        r.lat     = 32'(5 + ack_dly + stall_cyc);
        exp_q.push_back(r);
        for (int d = 0; d < ack_dly; d++) begin
            junk();
            imem_ack = 1'b0;
            tick();
        end
        junk();
        imem_ack   = 1'b1;
        imem_rdata = rd;
        tick();                       // DECODE
        junk();
        tick();                       // EXEC
        junk();
        if (br_exec) begin
            branch_taken  = 1'b1;
            branch_target = $urandom;
        end
        tick();                       // MEM
        for (int s = 0; s < stall_cyc; s++) begin
            junk();
            stall = 1'b1;
            tick();
        end
        junk();
        stall = 1'b0;
        tick();                       // WRITE
        junk();
        branch_taken  = br;
        branch_target = tgt;
        tick();                       // next FETCH
        imem_ack     = 1'b0;
        branch_taken = 1'b0;
        pc_m  = br ? {tgt[31:2], 2'b00} : pc_m + 32'd4;
        ret_m = ret_m + 32'd1;
    endtask

    // ---------------- monitor ----------------
    logic [31:0] last_instr = NOP_INSTR;
    logic        rst_prev = 1'b0;
    int          cyc = 0;

    always @(negedge clk) begin
        rec_t h;
        if (rst) begin
            chk("req_low_in_rst", 32'(imem_req), 32'd0);
            if (rst_prev) begin
                chk("rst_state", 32'(state), 32'd0);
                chk("rst_pc", pc, RESET_PC);
                chk("rst_instr", instr_raw, NOP_INSTR);
                chk("rst_retired", retired, 32'd0);
                chk("rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);
            end
            cyc = 0;
            last_instr = NOP_INSTR;
        end else begin
            cyc++;
            if (state == 3'd0) begin
                chk("fetch_req", 32'(imem_req), 32'd1);
                chk("fetch_instr_hold", instr_raw, last_instr);
                if (exp_q.size() > 0) begin
                    h = exp_q[0];
                    chk("fetch_addr", imem_addr, h.pc);
                    chk("fetch_pc_plus4", pc_plus4, h.pc + 32'd4);
                end
            end else if (exp_q.size() == 0) begin
                chk("unexpected_phase", 32'(state), 32'd0);
            end else begin
                h = exp_q[0];
                chk("busy_req_low", 32'(imem_req), 32'd0);
                chk("busy_pc", pc, h.pc);
                chk("busy_instr", instr_raw, h.instr);
                if (state == 3'd4) begin
                    void'(exp_q.pop_front());
                    chk("write_retired", retired, h.retired);
                    chk("latency", 32'(cyc), h.lat);
                    last_instr = h.instr;
                    cyc = 0;
                end
            end
        end
        rst_prev = rst;
    end

    // ---------------- stimulus ----------------
    initial begin
        // Initial reset: two edges with rst high.
        tick();
        tick();
        rst = 1'b0;

        // No-branch, zero-wait fetch.
        run_instr(0, 32'h0050_0093, 0, 1'b0, 32'd0, 1'b0);
        chk("pc_after_first", pc, 32'h0000_0004);
        chk("retired_after_first", retired, 32'd1);
        // Ack on the 4th FETCH cycle.
        run_instr(3, 32'h0000_0001, 0, 1'b0, 32'd0, 1'b0);
        // Two stall cycles in MEM.
        run_instr(0, $urandom, 2, 1'b0, 32'd0, 1'b0);
        // Redirect in WRITE with misaligned target.
        run_instr(1, $urandom, 0, 1'b1, 32'h0000_0103, 1'b0);
        chk("branch_pc", pc, 32'h0000_0100);
        // Branch pulse in EXEC has no effect.
        run_instr(0, $urandom, 1, 1'b0, 32'd0, 1'b1);
        chk("exec_branch_ignored", pc, 32'h0000_0104);
        // PC wrap: redirect to the top word, then fall through.
        run_instr(0, $urandom, 0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        chk("wrap_top_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
        run_instr(2, $urandom, 0, 1'b0, 32'd0, 1'b0);
        chk("wrap_pc", pc, 32'h0000_0000);

        // Reset during a FETCH wait cycle with a simultaneous ack.
        imem_ack = 1'b0;
        tick();
        tick();
        do_reset(1'b1);
        chk("midrst_instr", instr_raw, NOP_INSTR);
        chk("midrst_pc", pc, RESET_PC);
        chk("midrst_retired", retired, 32'd0);
        chk("midrst_state", 32'(state), 32'd0);

        // Random instruction stream.
        for (int i = 0; i < 60; i++) begin
            logic        br;
            logic [31:0] tgt;
            br  = ($urandom_range(0, 3) == 0);
            tgt = $urandom;
            run_instr($urandom_range(0, 4), $urandom, $urandom_range(0, 3), br, tgt,
                      1'($urandom_range(0, 1)));
        end

        tick();
        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("final_retired", retired, ret_m);
        chk("final_pc", pc, pc_m);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
